// File: rtl/serial_word_tx_pkg.sv
// rtl/serial_word_tx_pkg.sv - shared defaults and counter-width helper for the serial word transmitter
package serial_word_tx_pkg;

  localparam int SWT_CLK_DIV   = 4;
  localparam int SWT_LEAD_BITS = 1;
  localparam int SWT_GAP       = 2;

  // Counter width for a modulus n; never narrower than one bit so degenerate moduli still build.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adc_defs.vh
// rtl/adc_defs.vh - shared ADC/DAC serial link word-size definitions
`ifndef ADC_DEFS_VH
`define ADC_DEFS_VH
`define ADC_DATLEN 12
`define ADC_DATLEN_LOG2 4
`endif

// File: rtl/sclk_tick_gen.sv
// rtl/sclk_tick_gen.sv - divide counter emitting a one-cycle half_tick every CLK_DIV cycles while enabled
module sclk_tick_gen
  import serial_word_tx_pkg::*;
#(
  parameter int CLK_DIV = SWT_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic half_tick
);

  localparam int DW = cnt_w(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;

  assign half_tick = en && (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (!en || half_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/serial_word_tx.sv
// rtl/serial_word_tx.sv - parallel-to-serial word transmitter, cs_n-framed MSB-first on a divided sclk
`include "adc_defs.vh"

module serial_word_tx
  import serial_word_tx_pkg::*;
#(
  parameter int DATLEN    = `ADC_DATLEN,
  parameter int CLK_DIV   = SWT_CLK_DIV,
  parameter int LEAD_BITS = SWT_LEAD_BITS,
  parameter int GAP       = SWT_GAP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATLEN-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              sclk,
  output logic              cs_n,
  output logic              sdo,
  output logic              busy,
  output logic              done
);

  localparam int NBITS = LEAD_BITS + DATLEN;
  localparam int BW    = cnt_w(NBITS + 1);
  localparam int GW    = cnt_w(GAP);
  localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [NBITS-1:0] sr, sr_nx;
  logic [BW-1:0]    bit_cnt, bit_cnt_nx;
  logic [GW-1:0]    gap_cnt, gap_cnt_nx;
  logic             cs_n_nx, sclk_nx, done_nx;
  logic             shift_en, half_tick;

  assign shift_en = (state == ST_SHIFT);
  assign ready    = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);
  // Zero-extended load puts the lead zeros at the top, so the MSB is always the bit on the wire.
  assign sdo      = sr[NBITS-1];

  sclk_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (shift_en),
    .half_tick(half_tick)
  );

  always_comb begin
    state_nx   = state;
    sr_nx      = sr;
    bit_cnt_nx = bit_cnt;
    gap_cnt_nx = gap_cnt;
    cs_n_nx    = cs_n;
    sclk_nx    = sclk;
    done_nx    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (valid) begin
          sr_nx      = NBITS'(data);
          bit_cnt_nx = '0;
          cs_n_nx    = 1'b0;
          sclk_nx    = 1'b1;
          state_nx   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (half_tick) begin
          if (sclk) begin
            sclk_nx = 1'b0;
          end else if (bit_cnt == BIT_LAST) begin
            cs_n_nx    = 1'b1;
            sclk_nx    = 1'b1;
            sr_nx      = '0;
            done_nx    = 1'b1;
            bit_cnt_nx = '0;
            gap_cnt_nx = '0;
            state_nx   = (GAP == 0) ? ST_IDLE : ST_GAP;
          end else begin
            // Next bit starts with sclk rising; data moves only here.
            sclk_nx    = 1'b1;
            sr_nx      = sr << 1;
            bit_cnt_nx = bit_cnt + BW'(1);
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          gap_cnt_nx = '0;
          state_nx   = ST_IDLE;
        end else begin
          gap_cnt_nx = gap_cnt + GW'(1);
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      cs_n    <= 1'b1;
      sclk    <= 1'b1;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      sr      <= sr_nx;
      bit_cnt <= bit_cnt_nx;
      gap_cnt <= gap_cnt_nx;
      cs_n    <= cs_n_nx;
      sclk    <= sclk_nx;
      done    <= done_nx;
    end
  end

endmodule

// File: doc/serial_word_tx.md
# serial_word_tx

Parallel-to-serial word transmitter for the ADC/DAC serial link.
- Accepts one `ADC_DATLEN`-bit word over a valid/ready handshake.
- Emits the word as a chip-select-framed, MSB-first bit stream on a divided serial clock, preceded by leading 0 bits.
- Serves as the transmit end of the serial sample link: it drives DAC-style serial inputs and acts as the stimulus source for the serial receive path.

## Interface
Parameters:
- `DATLEN`, `ADC_DATLEN` (12): payload bits per frame.
- `CLK_DIV`, 4: `clk` cycles per sclk half-period; legal ≥1.
- `LEAD_BITS`, 1: leading 0 bits sent before the payload; legal ≥0.
- `GAP`, 2: idle `clk` cycles after cs_n rises before the next word is accepted; legal ≥0.

Ports:
- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `data` in DATLEN: word to send; sampled only on accept.
- `valid` in 1: `data` is valid.
- `ready` out 1: block can accept a word.
- `sclk` out 1: serial clock; idles high.
- `cs_n` out 1: frame select, active low.
- `sdo` out 1: serial data.
- `busy` out 1: high from accept until GAP ends.
- `done` out 1: one-cycle pulse when cs_n rises at frame end.

## Operation
- Clock and reset: one clock (`clk`); reset (`rst_n`) is asynchronous and active-low.
- Reset values:
  - `cs_n`=1, `sclk`=1, `sdo`=0.
  - `busy`=0, `done`=0, `ready`=1.
  - State IDLE, all counters 0.
- States IDLE → SHIFT → GAP → IDLE.
  - IDLE: `ready`=1. On `valid`&&`ready`, latch `data` into the shift register and enter SHIFT. `valid` without `ready` is ignored.
  - SHIFT: send NBITS = LEAD_BITS+DATLEN bits; `cs_n`=0 throughout.
    - Each bit occupies 2·CLK_DIV cycles: `sclk` high for CLK_DIV cycles, then low for CLK_DIV cycles.
    - `sdo` changes only at bit start, coincident with `sclk` rising (or with `cs_n` falling for bit 0).
    - `sdo` is stable across the `sclk` falling edge, which is where the receiver samples.
    - Bit order: LEAD_BITS zeros, then `data[DATLEN-1]` down to `data[0]`.
  - End of SHIFT (after the last low half-period): `cs_n`←1, `sclk`←1, `sdo`←0, `done`=1 for one cycle. Enter GAP, or IDLE if GAP=0.
  - GAP: count GAP cycles, then IDLE.
- `busy` = (state≠IDLE). `ready` = (state==IDLE).
- Counters:
  - Divide counter: width clog2(CLK_DIV), wraps CLK_DIV-1→0.
  - Bit counter: width clog2(NBITS+1).
  - No other arithmetic.
- Reset mid-frame: `cs_n`/`sclk` go high immediately (asynchronous), the frame is aborted, and no `done` pulse is produced.
- `data` changes after accept have no effect on the frame in flight.

## Timing
- Accept sampled at edge T:
  - `cs_n`=0 and first `sdo` bit valid from T+1.
  - `cs_n` low for NBITS·2·CLK_DIV cycles: 104 with defaults, T+1..T+104.
  - `cs_n`=1 and `done`=1 at T+105.
  - `ready`=1 at T+105+GAP (T+107 with defaults).
- Throughput: one word per 1+NBITS·2·CLK_DIV+GAP cycles when `valid` is held high.
- `sclk` falling edges for bit k: T+1+k·2·CLK_DIV+CLK_DIV.
- `done` and `ready` never assert in the same cycle unless GAP=0.

## Structure
- Shared include `adc_defs.vh` holds `ADC_DATLEN` and `ADC_DATLEN_LOG2`. The `DATLEN` default references this include.
- State encodings are local localparams.
- One sub-module, `sclk_tick_gen`: divide counter producing a one-cycle `half_tick` pulse every CLK_DIV cycles while enabled, cleared on disable.
- FSM, shift register and bit counter stay in `serial_word_tx`.

## Test plan
- Reset: assert `rst_n`=0 with `valid`=1 → `cs_n`=1, `sclk`=1, `sdo`=0, `ready`=1, `busy`=0, `done`=0; nothing accepted while in reset.
- Single word 12'hA5C, defaults:
  - Bits sampled on the 13 `sclk` falling edges = 0,1,0,1,0,0,1,0,1,1,1,0,0.
  - `cs_n` low exactly 104 cycles.
  - `done` at T+105, `ready` at T+107.
- Back-to-back, `valid` held with words 12'hFFF then 12'h001:
  - Second accept at T+107; `cs_n` high exactly 3 cycles between frames.
  - Second frame bits = 0, then eleven 0s, then 1.
- CLK_DIV=1, GAP=0, LEAD_BITS=0, word 12'h800:
  - `sclk` toggles every cycle; `cs_n` low 24 cycles.
  - Only the first sampled bit is 1.
  - `ready` and `done` both high at T+25.
- Reset mid-frame during bit 5 → `cs_n` and `sclk` high in the same cycle as `rst_n` falls, no `done`. After release, word 12'h3C3 is sent intact.
- Data stability: change `data` every cycle after accept of 12'h5A5 → serialized bits still match 12'h5A5.
